// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light controller front end: FSM state encoding
// and default timing parameters for the vehicle detector.
package traffic_pkg;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StReq   = 2'd1;
    localparam logic [1:0] StServe = 2'd2;

    localparam int unsigned DEB_CYC_DEF  = 4;
    localparam int unsigned MAX_WAIT_DEF = 16;

endpackage

// File: rtl/car_debounce.sv
// Two-flop synchronizer plus debounce counter for the raw loop-sensor level.
// The level only changes after DEB_CYC consecutive synchronized samples disagree with it.
module car_debounce
    import traffic_pkg::*;
#(
    parameter int unsigned DEB_CYC = DEB_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int unsigned CntW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

    logic            s1_q, s2_q;
    logic            level_q, level_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (s2_q != level_q) begin
            if (cnt_q == CntW'(DEB_CYC - 1)) begin
                level_d = s2_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            s1_q    <= raw;
            s2_q    <= s1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/car_detect.sv
// Vehicle detector front end: debounced sensor, held car request with grant handshake.
// Define CAR_DETECT_URGENT_EN to build the request aging counter and urgent flag.
module car_detect
    import traffic_pkg::*;
#(
    parameter int unsigned DEB_CYC  = DEB_CYC_DEF,
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEF,
    parameter int unsigned WAIT_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              loop_raw,
    input  logic              grant,
    output logic              present,
    output logic              car,
    output logic [WAIT_W-1:0] wait_cnt,
    output logic              urgent
);

    if (DEB_CYC < 1 || MAX_WAIT < 1 || MAX_WAIT >= (1 << WAIT_W)) begin : g_bad_params
        $error("car_detect: illegal DEB_CYC/MAX_WAIT/WAIT_W combination");
    end

    logic [1:0] state_q, state_d;

    car_debounce #(
        .DEB_CYC(DEB_CYC)
    ) u_debounce (
        .clk  (clk),
        .rst  (rst),
        .raw  (loop_raw),
        .level(present)
    );

    // A fallen present always wins over grant, in both REQ and SERVE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (present) state_d = StReq;
            StReq: begin
                if (!present)   state_d = StIdle;
                else if (grant) state_d = StServe;
            end
            StServe: begin
                if (!present)    state_d = StIdle;
                else if (!grant) state_d = StReq;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    assign car = (state_q != StIdle);

`ifdef CAR_DETECT_URGENT_EN
    logic [WAIT_W-1:0] wait_q, wait_d;

    // Age restarts when green ends with the car still there; frozen while served.
    always_comb begin
        wait_d = wait_q;
        if (state_d == StIdle) begin
            wait_d = '0;
        end else if (state_q == StServe && state_d == StReq) begin
            wait_d = '0;
        end else if (state_q == StReq && wait_q != WAIT_W'(MAX_WAIT)) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end

    assign wait_cnt = wait_q;
    assign urgent   = (state_q == StReq) && (wait_q == WAIT_W'(MAX_WAIT));
`else
    assign wait_cnt = '0;
    assign urgent   = 1'b0;
`endif

endmodule

// File: tb/tb_car_detect.sv
// Randomized and directed bench for car_detect against a cycle-level behavioural model.
// Expectations for wait_cnt/urgent follow whether CAR_DETECT_URGENT_EN is defined.
module tb_car_detect;

    localparam int unsigned DEB_CYC  = 4;
    localparam int unsigned MAX_WAIT = 16;
    localparam int unsigned WAIT_W   = 5;
`ifdef CAR_DETECT_URGENT_EN
    localparam bit AgeOn = 1'b1;
`else
    localparam bit AgeOn = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              loop_raw = 1'b0;
    logic              grant = 1'b0;
    logic              present, car, urgent;
    logic [WAIT_W-1:0] wait_cnt;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    car_detect #(
        .DEB_CYC (DEB_CYC),
        .MAX_WAIT(MAX_WAIT),
        .WAIT_W  (WAIT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .loop_raw(loop_raw),
        .grant   (grant),
        .present (present),
        .car     (car),
        .wait_cnt(wait_cnt),
        .urgent  (urgent)
    );

    // Model: raw history, run length of disagreeing samples, and request phase/age.
    bit m_r1, m_r2, m_present;
    int m_run;
    int m_phase;  // 0 no request, 1 waiting for green, 2 being served
    int m_age;

    task automatic model_reset();
        m_r1 = 0; m_r2 = 0; m_present = 0; m_run = 0; m_phase = 0; m_age = 0;
    endtask

    function automatic logic [WAIT_W+2:0] model_out();
        logic [WAIT_W-1:0] w;
        logic              u;
        w = AgeOn ? WAIT_W'(m_age) : '0;
        u = AgeOn && m_phase == 1 && m_age == int'(MAX_WAIT);
        return {m_present, logic'(m_phase != 0), w, u};
    endfunction

    function automatic logic [WAIT_W+2:0] dut_out();
        return {present, car, wait_cnt, urgent};
    endfunction

    // Apply inputs for one clock, advance the model with pre-edge values, settle 1 unit.
    task automatic tick(input bit raw, input bit gnt);
        loop_raw = raw;
        grant    = gnt;
        @(posedge clk);
        case (m_phase)
            0: if (m_present) begin m_phase = 1; m_age = 0; end
            1: begin
                if (!m_present) begin
                    m_phase = 0; m_age = 0;
                end else begin
                    m_age = (m_age < int'(MAX_WAIT)) ? m_age + 1 : m_age;
                    if (gnt) m_phase = 2;
                end
            end
            default: begin
                if (!m_present) begin m_phase = 0; m_age = 0; end
                else if (!gnt) begin m_phase = 1; m_age = 0; end
            end
        endcase
        if (m_r2 != m_present) begin
            m_run++;
            if (m_run == int'(DEB_CYC)) begin m_present = m_r2; m_run = 0; end
        end else begin
            m_run = 0;
        end
        m_r2 = m_r1;
        m_r1 = raw;
        #1;
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        #2 model_reset();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        int first_present = 0;
        int first_car = 0;
        rst = 1'b0; loop_raw = 1'b1; grant = 1'b0;
        model_reset();
        #3;
        vectors++; if (present !== 1'b0) begin errors++; $display("FAIL reset_present: got %b want 0", present); end
        vectors++; if (car !== 1'b0) begin errors++; $display("FAIL reset_car: got %b want 0", car); end
        vectors++; if (wait_cnt !== '0) begin errors++; $display("FAIL reset_wait: got %0d want 0", wait_cnt); end
        vectors++; if (urgent !== 1'b0) begin errors++; $display("FAIL reset_urgent: got %b want 0", urgent); end
        @(posedge clk);
        #1 rst = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            tick(1, 0);
            if (present === 1'b1 && first_present == 0) first_present = n;
            if (car === 1'b1 && first_car == 0) first_car = n;
        end
        vectors++;
        if (first_present != int'(DEB_CYC) + 2) begin
            errors++; $display("FAIL reset_detect_latency: present at edge %0d want %0d", first_present, DEB_CYC + 2);
        end
        vectors++;
        if (first_car != int'(DEB_CYC) + 3) begin
            errors++; $display("FAIL reset_car_latency: car at edge %0d want %0d", first_car, DEB_CYC + 3);
        end
    endtask

    task automatic test_glitch();
        int n;
        do_reset();
        tick(1, 0); tick(1, 0);
        for (int i = 0; i < 12; i++) begin
            tick(0, 0);
            vectors++;
            if (present !== 1'b0 || car !== 1'b0 || dut_out() !== model_out()) begin
                errors++; $display("FAIL glitch_short: got %h want %h", dut_out(), model_out());
            end
        end
        n = 0;
        while (present !== 1'b1 && n < 20) begin tick(1, 0); n++; end
        tick(0, 0);
        for (int i = 0; i < 10; i++) begin
            tick(1, 0);
            vectors++;
            if (present !== 1'b1 || dut_out() !== model_out()) begin
                errors++; $display("FAIL glitch_dropout: got %h want %h", dut_out(), model_out());
            end
        end
    endtask

    task automatic test_service();
        int n = 0;
        do_reset();
        while (car !== 1'b1 && n < 20) begin tick(1, 0); n++; end
        tick(1, 0); tick(1, 0); tick(1, 1);
        vectors++;
        if (car !== 1'b1 || wait_cnt !== (AgeOn ? WAIT_W'(3) : WAIT_W'(0)) || dut_out() !== model_out()) begin
            errors++; $display("FAIL service_grant: got car=%b wait=%0d want car=1 wait=%0d", car, wait_cnt, AgeOn ? 3 : 0);
        end
        for (int i = 0; i < 4; i++) begin
            tick(1, 1);
            vectors++;
            if (dut_out() !== model_out()) begin
                errors++; $display("FAIL service_hold: got %h want %h", dut_out(), model_out());
            end
        end
        n = 0;
        while (present !== 1'b0 && n < 20) begin tick(0, 1); n++; end
        vectors++;
        if (car !== 1'b1 || present !== 1'b0) begin
            errors++; $display("FAIL service_leave_edge: got car=%b present=%b want 1 0", car, present);
        end
        tick(0, 1);
        vectors++;
        if (car !== 1'b0 || dut_out() !== model_out()) begin
            errors++; $display("FAIL service_idle: got %h want %h", dut_out(), model_out());
        end
    endtask

    task automatic test_aging();
        int n = 0;
        do_reset();
        while (car !== 1'b1 && n < 20) begin tick(1, 0); n++; end
        for (int i = 1; i <= 20; i++) begin
            tick(1, 0);
            vectors++;
            if (wait_cnt !== (AgeOn ? WAIT_W'(i < 16 ? i : 16) : WAIT_W'(0))
                || urgent !== (AgeOn && i >= 16) || dut_out() !== model_out()) begin
                errors++; $display("FAIL aging_cycle%0d: got wait=%0d urgent=%b", i, wait_cnt, urgent);
            end
        end
        tick(1, 1);
        vectors++;
        if (urgent !== 1'b0 || car !== 1'b1 || dut_out() !== model_out()) begin
            errors++; $display("FAIL aging_granted: got %h want %h", dut_out(), model_out());
        end
    endtask

    task automatic test_green_early();
        tick(1, 0);
        vectors++;
        if (car !== 1'b1 || wait_cnt !== '0 || urgent !== 1'b0 || dut_out() !== model_out()) begin
            errors++; $display("FAIL green_early_req: got %h want %h", dut_out(), model_out());
        end
        tick(1, 0);
        vectors++;
        if (wait_cnt !== (AgeOn ? WAIT_W'(1) : WAIT_W'(0)) || dut_out() !== model_out()) begin
            errors++; $display("FAIL green_early_restart: got wait=%0d want %0d", wait_cnt, AgeOn ? 1 : 0);
        end
    endtask

    task automatic test_simultaneous();
        int n = 0;
        do_reset();
        while (car !== 1'b1 && n < 20) begin tick(1, 0); n++; end
        n = 0;
        while (present !== 1'b0 && n < 20) begin tick(0, 0); n++; end
        tick(0, 1);
        vectors++;
        if (car !== 1'b0 || dut_out() !== model_out()) begin
            errors++; $display("FAIL simul_req: got %h want %h", dut_out(), model_out());
        end
        n = 0;
        while (car !== 1'b1 && n < 20) begin tick(1, 0); n++; end
        tick(1, 1);
        n = 0;
        while (present !== 1'b0 && n < 20) begin tick(0, 1); n++; end
        tick(0, 0);
        vectors++;
        if (car !== 1'b0 || dut_out() !== model_out()) begin
            errors++; $display("FAIL simul_serve: got %h want %h", dut_out(), model_out());
        end
    endtask

    task automatic test_random();
        int raw_hold = 0;
        int gnt_hold = 0;
        bit r = 0;
        bit g = 0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (raw_hold == 0) begin r = 1'($urandom_range(0, 1)); raw_hold = $urandom_range(1, 12); end
            if (gnt_hold == 0) begin g = 1'($urandom_range(0, 1)); gnt_hold = $urandom_range(1, 25); end
            raw_hold--; gnt_hold--;
            if (i == 1500) begin
                #3 rst = 1'b0;
                #1;
                vectors++;
                if (dut_out() !== '0) begin
                    errors++; $display("FAIL random_midreset: got %h want 0", dut_out());
                end
                model_reset();
                #1 rst = 1'b1;
            end
            tick(r, g);
            vectors++;
            if (dut_out() !== model_out()) begin
                errors++; $display("FAIL random_cycle%0d: got %h want %h", i, dut_out(), model_out());
            end
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_service();
        test_aging();
        test_green_early();
        test_simultaneous();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
